// File: rtl/pdm_decimator.sv
// PDM-to-PCM front end: generates the microphone PDM clock, integrates the 1-bit
// stream through a 5th-order CIC, decimates by 2^LOG2_DECIM, and runs the five comb
// stages one per clock through a shared subtractor. Output is a valid/ready PCM
// stream with a sticky overrun flag.
module pdm_decimator #(
    parameter int PDM_DIV    = 4,
    parameter int LOG2_DECIM = 6,
    parameter int OUT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    pdm_clk,
    input  logic                    pdm_data,
    output logic signed [OUT_W-1:0] pcm,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    overrun
);

    localparam int W  = 2 + 5 * LOG2_DECIM;
    localparam int DW = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_C0, S_C1, S_C2, S_C3, S_C4, S_OUT
    } state_t;

    logic [DW-1:0]         div_q;
    logic                  pdm_clk_q;
    logic [LOG2_DECIM-1:0] dec_q;
    logic [4:0][W-1:0]     integ_q;
    logic                  go_q;
    state_t                state_q;
    logic [W-1:0]          acc_q;
    logic [4:0][W-1:0]     dly_q;
    logic [OUT_W-1:0]      pcm_q;
    logic                  valid_q;
    logic                  overrun_q;

    logic                  div_tc;
    logic                  strobe;
    logic                  dec_wrap;
    logic [W-1:0]          x_in;
    logic [W-1:0]          dly_sel;
    logic [W-1:0]          comb_d;

    // Strobe fires in the cycle where pdm_clk is about to fall; that edge samples pdm_data.
    assign div_tc   = (div_q == DW'(PDM_DIV - 1));
    assign strobe   = div_tc & pdm_clk_q;
    assign dec_wrap = strobe & (dec_q == '1);
    // Bit 1 -> +1, bit 0 -> -1 (all ones in two's complement).
    assign x_in     = pdm_data ? W'(1) : '1;

    // PDM clock divider: toggle at terminal count, 50% duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
        end else if (div_tc) begin
            div_q     <= '0;
            pdm_clk_q <= ~pdm_clk_q;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Integrator cascade and decimation counter; modular wrap is what makes the CIC exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q <= '0;
            dec_q   <= '0;
            go_q    <= 1'b0;
        end else begin
            go_q <= dec_wrap;
            if (strobe) begin
                dec_q      <= dec_q + LOG2_DECIM'(1);
                integ_q[0] <= integ_q[0] + x_in;
                for (int k = 1; k < 5; k++)
                    integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
        end
    end

    // Select the delay register belonging to the comb stage being evaluated.
    always_comb begin
        dly_sel = '0;
        case (state_q)
            S_C0:    dly_sel = dly_q[0];
            S_C1:    dly_sel = dly_q[1];
            S_C2:    dly_sel = dly_q[2];
            S_C3:    dly_sel = dly_q[3];
            S_C4:    dly_sel = dly_q[4];
            default: dly_sel = '0;
        endcase
        comb_d = acc_q - dly_sel;
    end

    // Comb sequencer: snapshot, five comb stages on one subtractor, then load output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            dly_q     <= '0;
            pcm_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // A transfer drops valid unless OUT reloads it below.
            if (valid_q && pcm_ready)
                valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go_q) begin
                        acc_q   <= integ_q[4];
                        state_q <= S_C0;
                    end
                end
                S_C0: begin acc_q <= comb_d; dly_q[0] <= acc_q; state_q <= S_C1; end
                S_C1: begin acc_q <= comb_d; dly_q[1] <= acc_q; state_q <= S_C2; end
                S_C2: begin acc_q <= comb_d; dly_q[2] <= acc_q; state_q <= S_C3; end
                S_C3: begin acc_q <= comb_d; dly_q[3] <= acc_q; state_q <= S_C4; end
                S_C4: begin acc_q <= comb_d; dly_q[4] <= acc_q; state_q <= S_OUT; end
                S_OUT: begin
                    pcm_q   <= acc_q[W-1 -: OUT_W];
                    valid_q <= 1'b1;
                    // Overwriting a sample nobody took this cycle is an overrun.
                    if (valid_q && !pcm_ready)
                        overrun_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pdm_clk   = pdm_clk_q;
    assign pcm       = pcm_q;
    assign pcm_valid = valid_q;
    assign overrun   = overrun_q;

endmodule
